// File: rtl/drum_dot_accum.sv
// Dot-product accumulator behind the DRUM6 multiplier: sums len products, then hands off one result.
// Optional DRUM_ACC_SAT_EN: saturate the accumulator at all-ones instead of wrapping.
module drum_dot_accum #(
    parameter int ACC_W = 72,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [63:0]      p_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

`ifdef DRUM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] remaining;
    logic             ovf;
    logic             p_ready_q;
    logic             o_valid_q;
    logic             busy_q;
    logic [ACC_W:0]   sum_p0;
    logic             xfer;

    // Carry out of the top accumulator bit either wraps away or pins the result at all-ones.
    function automatic logic [ACC_W-1:0] clamp_sum(input logic [ACC_W:0] s);
        return (SAT && s[ACC_W]) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign xfer   = p_valid & p_ready_q;
    assign sum_p0 = {1'b0, acc} + (ACC_W+1)'(p_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
            p_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        ovf    <= 1'b0;
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            remaining <= len;
                            p_ready_q <= 1'b1;
                            state     <= ACC;
                        end else begin
                            o_valid_q <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                ACC: begin
                    if (xfer) begin
                        acc       <= clamp_sum(sum_p0);
                        ovf       <= ovf | sum_p0[ACC_W];
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            p_ready_q <= 1'b0;
                            o_valid_q <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    p_ready_q <= 1'b0;
                    o_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Sum stays on o_sum after the handshake until the next start clears it.
    assign busy    = busy_q;
    assign p_ready = p_ready_q;
    assign o_valid = o_valid_q;
    assign o_sum   = acc;
    assign o_ovf   = ovf;

endmodule

// File: tb/tb_drum_dot_accum.sv
// Directed bench for drum_dot_accum; a 72-bit and a 64-bit instance share one stimulus stream.
module tb_drum_dot_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic        p_valid;
    logic [63:0] p_data;
    logic        o_ready;

    logic        busy_a, p_ready_a, o_valid_a, o_ovf_a;
    logic [71:0] o_sum_a;
    logic        busy_b, p_ready_b, o_valid_b, o_ovf_b;
    logic [63:0] o_sum_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    drum_dot_accum #(.ACC_W(72), .LEN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_a),
        .p_valid(p_valid), .p_ready(p_ready_a), .p_data(p_data),
        .o_valid(o_valid_a), .o_ready(o_ready), .o_sum(o_sum_a), .o_ovf(o_ovf_a)
    );

    drum_dot_accum #(.ACC_W(64), .LEN_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_b),
        .p_valid(p_valid), .p_ready(p_ready_b), .p_data(p_data),
        .o_valid(o_valid_b), .o_ready(o_ready), .o_sum(o_sum_b), .o_ovf(o_ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; p_valid = 1'b0; p_data = '0; o_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy",    128'(busy_a),    128'd0);
        chk("rst_p_ready", 128'(p_ready_a), 128'd0);
        chk("rst_o_valid", 128'(o_valid_a), 128'd0);
        chk("rst_o_sum",   128'(o_sum_a),   128'd0);
        chk("rst_o_ovf",   128'(o_ovf_a),   128'd0);
        rst_n = 1'b1;

        // len=3, products 5,7,11 back to back
        o_ready = 1'b1;
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0;
        chk("t1_p_ready", 128'(p_ready_a), 128'd1);
        chk("t1_busy",    128'(busy_a),    128'd1);
        p_valid = 1'b1; p_data = 64'd5;
        tick();
        p_data = 64'd7;
        tick();
        p_data = 64'd11;
        chk("t1_no_early_valid", 128'(o_valid_a), 128'd0);
        tick();
        p_valid = 1'b0;
        chk("t1_o_valid", 128'(o_valid_a), 128'd1);
        chk("t1_o_sum",   128'(o_sum_a),   128'd23);
        chk("t1_o_ovf",   128'(o_ovf_a),   128'd0);
        chk("t1_p_ready_out", 128'(p_ready_a), 128'd0);
        tick();
        chk("t1_idle_valid", 128'(o_valid_a), 128'd0);
        chk("t1_idle_busy",  128'(busy_a),    128'd0);
        chk("t1_sum_held",   128'(o_sum_a),   128'd23);

        // len=0 goes straight to a zero result
        o_ready = 1'b0;
        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
        chk("t2_o_valid", 128'(o_valid_a), 128'd1);
        chk("t2_o_sum",   128'(o_sum_a),   128'd0);
        chk("t2_o_ovf",   128'(o_ovf_a),   128'd0);
        chk("t2_p_ready", 128'(p_ready_a), 128'd0);
        o_ready = 1'b1;
        tick();
        chk("t2_done", 128'(o_valid_a), 128'd0);

        // len=4 with p_valid toggling; idle-cycle data must be ignored
        o_ready = 1'b0;
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            p_valid = (i % 2 == 0);
            p_data  = (i % 2 == 0) ? 64'(i + 1) : 64'd100;
            tick();
        end
        p_valid = 1'b0;
        chk("t3_o_valid", 128'(o_valid_a), 128'd1);
        chk("t3_o_sum",   128'(o_sum_a),   128'd16);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("t3_stall_valid", 128'(o_valid_a), 128'd1);
            chk("t3_stall_sum",   128'(o_sum_a),   128'd16);
        end
        o_ready = 1'b1;
        tick();
        chk("t3_done", 128'(o_valid_a), 128'd0);

        // two all-ones products: fits in 72 bits, overflows 64 bits
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b0;
        p_valid = 1'b1; p_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        p_valid = 1'b0;
        chk("t4_sum72", 128'(o_sum_a), 128'h1_FFFF_FFFF_FFFF_FFFE);
        chk("t4_ovf72", 128'(o_ovf_a), 128'd0);
`ifdef DRUM_ACC_SAT_EN
        chk("t4_sum64", 128'(o_sum_b), 128'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("t4_sum64", 128'(o_sum_b), 128'hFFFF_FFFF_FFFF_FFFE);
`endif
        chk("t4_ovf64", 128'(o_ovf_b), 128'd1);
        tick();
        chk("t4_done64", 128'(o_valid_b), 128'd0);

        // async reset after 2 of 5 products, then a clean len=1 job
        start = 1'b1; len = 16'd5;
        tick();
        start = 1'b0;
        p_valid = 1'b1; p_data = 64'd100;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy",    128'(busy_a),    128'd0);
        chk("t5_rst_p_ready", 128'(p_ready_a), 128'd0);
        chk("t5_rst_o_valid", 128'(o_valid_a), 128'd0);
        chk("t5_rst_o_sum",   128'(o_sum_a),   128'd0);
        chk("t5_rst_o_ovf",   128'(o_ovf_a),   128'd0);
        p_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b1; len = 16'd1;
        tick();
        start = 1'b0;
        p_valid = 1'b1; p_data = 64'd9;
        tick();
        p_valid = 1'b0;
        chk("t5_o_valid", 128'(o_valid_a), 128'd1);
        chk("t5_o_sum",   128'(o_sum_a),   128'd9);
        chk("t5_o_ovf",   128'(o_ovf_a),   128'd0);
        tick();

        // start during ACC with another len must be ignored
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b1; len = 16'd5;
        p_valid = 1'b1; p_data = 64'd20;
        tick();
        start = 1'b0;
        p_data = 64'd22;
        tick();
        p_valid = 1'b0;
        chk("t6_o_valid", 128'(o_valid_a), 128'd1);
        chk("t6_o_sum",   128'(o_sum_a),   128'd42);
        tick();
        chk("t6_idle_valid", 128'(o_valid_a), 128'd0);
        chk("t6_idle_busy",  128'(busy_a),    128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
